// File: rtl/scanline_reader.sv
// scanline_reader
// Streams one scanline of 15-bit RGB555 colours out of a combinational-read
// colour RAM. Each pixel is expanded to 24-bit RGB888 and presented on a
// single-register valid/ready output stage.
//
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   start, line  : one-cycle request to read the scanline given by port line
//   busy, done   : busy while a line is in flight; done pulses once at the end
//   ram_addr     : colour RAM address (column counter while reading, else 0)
//   ram_rd_data  : RAM word {B5,G5,R5} for ram_addr, same cycle
//   pix_valid, pix_ready        : output handshake
//   pix_rgb, pix_x, pix_y, pix_last : pixel payload; last marks column LINE_PIXELS-1
module scanline_reader #(
  parameter int LINE_PIXELS = 160,
  parameter int MAX_LINE    = 143
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  line,
  output logic        busy,
  output logic        done,
  output logic [7:0]  ram_addr,
  input  logic [14:0] ram_rd_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_rgb,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        pix_last
);

  localparam logic [7:0] LAST_COL = 8'(LINE_PIXELS - 1);
  localparam logic [7:0] MAX_LN   = 8'(MAX_LINE);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_line;
  logic        r_done;
  logic        r_pix_valid;
  logic [23:0] r_pix_rgb;
  logic [7:0]  r_pix_x;
  logic [7:0]  r_pix_y;
  logic        r_pix_last;

  logic        w_load;
  logic [23:0] w_rgb;
  logic [4:0]  w_r;
  logic [4:0]  w_g;
  logic [4:0]  w_b;

  // Replicating the top bits maps 0 -> 0x00 and 31 -> 0xFF exactly.
  always_comb begin
    w_r   = ram_rd_data[4:0];
    w_g   = ram_rd_data[9:5];
    w_b   = ram_rd_data[14:10];
    w_rgb = {w_r, w_r[4:2], w_g, w_g[4:2], w_b, w_b[4:2]};
  end

  // The output register refills whenever it is empty or being drained this cycle.
  assign w_load = (r_state == READ) && (!r_pix_valid || pix_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_line      <= '0;
      r_done      <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_rgb   <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && (line <= MAX_LN)) begin
            r_line  <= line;
            r_cnt   <= '0;
            r_state <= READ;
          end
        end
        READ: begin
          if (w_load) begin
            r_pix_valid <= 1'b1;
            r_pix_rgb   <= w_rgb;
            r_pix_x     <= r_cnt;
            r_pix_y     <= r_line;
            r_pix_last  <= (r_cnt == LAST_COL);
            // Counter parks on the last column instead of wrapping.
            if (r_cnt == LAST_COL) begin
              r_state <= DRAIN;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (r_pix_valid && pix_ready) begin
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign ram_addr  = (r_state == READ) ? r_cnt : '0;
  assign pix_valid = r_pix_valid;
  assign pix_rgb   = r_pix_rgb;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_last  = r_pix_last;

endmodule

// File: tb/tb_scanline_reader.sv
// Testbench for scanline_reader: RAM model, pixel scoreboard, stall-stability
// monitor, start-legality vector table and hand-written corner sequences.
module tb_scanline_reader;

  logic        clk = 1'b0;
  logic        rst, start, pix_ready;
  logic [7:0]  line;
  logic        busy, done, pix_valid, pix_last;
  logic [7:0]  ram_addr, pix_x, pix_y;
  logic [14:0] ram_rd_data;
  logic [23:0] pix_rgb;

  logic [14:0] mem [0:159];
  assign ram_rd_data = mem[ram_addr];

  always #5 clk = ~clk;

  scanline_reader #(.LINE_PIXELS(160), .MAX_LINE(143)) dut (
    .clk(clk), .rst(rst), .start(start), .line(line), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_rd_data(ram_rd_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_rgb(pix_rgb), .pix_x(pix_x), .pix_y(pix_y),
    .pix_last(pix_last)
  );

  int checks = 0;
  int passes = 0;
  logic [40:0] q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [23:0] exp_rgb(input logic [14:0] d);
    logic [4:0] r, g, b;
    r = d[4:0];
    g = d[9:5];
    b = d[14:10];
    return {r, r[4:2], g, g[4:2], b, b[4:2]};
  endfunction

  task automatic push_line(input logic [7:0] l);
    for (int x = 0; x < 160; x++)
      q.push_back({exp_rgb(mem[x]), 8'(x), l, (x == 159)});
  endtask

  // Monitor: scoreboard pop on every handshake; hold check after every stall.
  logic        prev_stall = 1'b0;
  logic [40:0] held;
  logic [7:0]  held_addr;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold", {pix_valid, pix_rgb, pix_x, pix_y, pix_last}, {1'b1, held});
        chk("stall_addr", ram_addr, held_addr);
      end
      if (pix_valid && pix_ready) begin
        if (q.size() == 0) chk("extra_pixel", pix_x, 8'hEE);
        else chk("pixel", {pix_rgb, pix_x, pix_y, pix_last}, q.pop_front());
      end
      prev_stall = pix_valid && !pix_ready;
      held       = {pix_rgb, pix_x, pix_y, pix_last};
      held_addr  = ram_addr;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    line  = l;
    tick;
    start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: alternate ready plus a 10-cycle stall at x=80.
  task automatic wait_done(input int mode);
    int stall = 0;
    bit did80 = 0;
    bit got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (mode == 0) pix_ready = 1'b1;
      else begin
        if (!did80 && pix_valid && pix_x == 8'd80) begin
          did80 = 1;
          stall = 10;
        end
        if (stall > 0) begin
          pix_ready = 1'b0;
          stall--;
        end else pix_ready = i[0];
      end
      tick;
      if (done) got = 1;
    end
    pix_ready = 1'b1;
    chk("done_seen", 64'(got), 1);
    chk("all_beats", 64'(q.size()), 0);
    chk("busy_after_done", busy, 0);
  endtask

  typedef struct { logic [14:0] data; logic [23:0] rgb; } exp_vec_t;
  typedef struct { logic [7:0] ln; logic acc; } start_vec_t;

  initial begin
    exp_vec_t   ev [6];
    start_vec_t sv [5];
    bit         hit;

    ev[0] = '{15'h7FFF, 24'hFFFFFF};
    ev[1] = '{15'h001F, 24'hFF0000};
    ev[2] = '{15'h0000, 24'h000000};
    ev[3] = '{15'h03E0, 24'h00FF00};
    ev[4] = '{15'h7C00, 24'h0000FF};
    ev[5] = '{15'h4210, 24'h848484};
    sv[0] = '{8'd143, 1'b1};
    sv[1] = '{8'd144, 1'b0};
    sv[2] = '{8'd255, 1'b0};
    sv[3] = '{8'd0,   1'b1};
    sv[4] = '{8'd77,  1'b1};

    for (int i = 0; i < 160; i++) mem[i] = 15'(i);
    rst = 1'b1; start = 1'b0; line = '0; pix_ready = 1'b1;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_payload", {pix_rgb, pix_x, pix_y, pix_last}, 0);
    rst = 1'b0;
    tick;

    // Basic line with exact latency and no gaps.
    push_line(8'd5);
    do_start(8'd5);
    chk("lat_busy", busy, 1);
    chk("lat_addr", ram_addr, 0);
    chk("lat_valid_early", pix_valid, 0);
    tick;
    chk("lat_valid", pix_valid, 1);
    chk("lat_x0", pix_x, 0);
    for (int k = 1; k < 160; k++) begin
      tick;
      chk("no_gap", {pix_valid, done}, 2'b10);
    end
    tick;
    chk("done_pulse", done, 1);
    chk("done_valid", pix_valid, 0);
    chk("done_busy", busy, 0);
    chk("basic_beats", 64'(q.size()), 0);
    tick;
    chk("done_one_cycle", done, 0);

    // Expansion vectors loaded at the head of the line.
    for (int i = 0; i < 6; i++) mem[i] = ev[i].data;
    for (int x = 0; x < 160; x++)
      q.push_back({(x < 6) ? ev[x].rgb : exp_rgb(mem[x]), 8'(x), 8'd2, (x == 159)});
    do_start(8'd2);
    wait_done(0);

    // Backpressure with alternate ready and a long stall.
    push_line(8'd6);
    do_start(8'd6);
    wait_done(1);

    // Start legality table.
    for (int i = 0; i < 5; i++) begin
      if (sv[i].acc) push_line(sv[i].ln);
      do_start(sv[i].ln);
      chk("start_busy", busy, sv[i].acc);
      if (sv[i].acc) wait_done(0);
      else begin
        tick;
        chk("ignored_idle", {busy, done, pix_valid}, 0);
      end
    end

    // Overlapping start is ignored.
    push_line(8'd12);
    do_start(8'd12);
    repeat (20) tick;
    do_start(8'd7);
    chk("overlap_busy", busy, 1);
    wait_done(0);
    tick; tick;
    chk("overlap_no_rerun", {busy, pix_valid}, 0);

    // Reset mid-line, then reset-over-start priority, then a fresh line.
    push_line(8'd3);
    do_start(8'd3);
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (pix_valid && pix_x == 8'd50) hit = 1;
      else tick;
    end
    chk("reached_x50", 64'(hit), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    q.delete();
    chk("midrst_state", {busy, done, pix_valid, pix_last}, 0);
    chk("midrst_addr", ram_addr, 0);
    chk("midrst_payload", {pix_rgb, pix_x, pix_y}, 0);
    hit = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (done) hit = 1;
    end
    chk("midrst_no_done", 64'(hit), 0);
    rst = 1'b1; start = 1'b1; line = 8'd4;
    tick;
    rst = 1'b0; start = 1'b0;
    tick;
    chk("rst_over_start", busy, 0);
    push_line(8'd9);
    do_start(8'd9);
    wait_done(0);

    // Back-to-back: second start while done is showing.
    push_line(8'd20);
    do_start(8'd20);
    wait_done(0);
    push_line(8'd21);
    do_start(8'd21);
    chk("b2b_busy", busy, 1);
    chk("b2b_addr", ram_addr, 0);
    tick;
    chk("b2b_first", {pix_valid, pix_x}, {1'b1, 8'd0});
    wait_done(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
